// File: rtl/clock_edit_controller.sv
// Edit/alarm sequencer for the digital clock: mode arbitration, debounced buttons, digit editing, alarm ring.
// Latency: switches reach the FSM after 2 cycles; a button press edits a digit 2 + DEBOUNCE_CYCLES + 1 cycles after its edge.
// Backpressure: none; load_time is a one-cycle strobe that the clock counters must accept when it fires.

module clock_edit_controller #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int TICKS_PER_SEC   = 1000,
  parameter int BLINK_HALF      = 250,
  parameter int ALARM_RING_SEC  = 5
) (
  input  logic        clk_1khz,
  input  logic        switch_clr,
  input  logic        button_pos,
  input  logic        button_inc,
  input  logic        switch_setting,
  input  logic        switch_alarm,
  input  logic [23:0] cur_time,
  output logic [23:0] edit_time,
  output logic        display_sel,
  output logic        load_time,
  output logic [23:0] alarm_time,
  output logic        alarm_valid,
  output logic [5:0]  blank,
  output logic        ring
);

  localparam int RING_CYCLES = ALARM_RING_SEC * TICKS_PER_SEC;
  localparam int DB_W        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BL_W        = $clog2(BLINK_HALF + 1);
  localparam int RING_W      = $clog2(RING_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_EDIT_TIME,
    ST_EDIT_ALARM,
    ST_COMMIT_TIME,
    ST_COMMIT_ALARM
  } state_e;

  typedef enum logic [1:0] {
    REQ_RUN,
    REQ_TIME,
    REQ_ALARM
  } req_e;

  // sync bit order: {alarm switch, setting switch, inc button, pos button}
  logic [3:0]           sync1_q, sync2_q;
  logic [1:0]           db_q, db_prev_q;
  logic [1:0][DB_W-1:0] db_cnt_q;
  logic                 pos_ev, inc_ev;
  req_e                 req;

  state_e               state_q, state_d;
  logic [1:0]           pos_q, pos_d;
  logic [23:0]          edit_q, edit_d;
  logic [23:0]          alarm_q, alarm_d;
  logic                 valid_q, valid_d;
  logic                 enter_edit;

  logic [23:0]          cur_prev_q;
  logic                 ring_q, ring_match;
  logic [RING_W-1:0]    ring_cnt_q;
  logic [BL_W-1:0]      blink_cnt_q;
  logic                 phase_q;

  // Digit increment with legal-range wrap and no carry; bumping hh to 2 clamps an out-of-range hl.
  function automatic logic [23:0] inc_digit(input logic [23:0] t, input logic [1:0] p);
    logic [23:0] r;
    r = t;
    case (p)
      2'd0: r[11:8]  = (t[11:8]  >= 4'd9) ? 4'd0 : t[11:8]  + 4'd1;
      2'd1: r[15:12] = (t[15:12] >= 4'd5) ? 4'd0 : t[15:12] + 4'd1;
      2'd2: begin
        if (t[23:20] == 4'd2) r[19:16] = (t[19:16] >= 4'd3) ? 4'd0 : t[19:16] + 4'd1;
        else                  r[19:16] = (t[19:16] >= 4'd9) ? 4'd0 : t[19:16] + 4'd1;
      end
      default: begin
        r[23:20] = (t[23:20] >= 4'd2) ? 4'd0 : t[23:20] + 4'd1;
        if (r[23:20] == 4'd2 && t[19:16] > 4'd3) r[19:16] = 4'd0;
      end
    endcase
    return r;
  endfunction

  // Synchronize all asynchronous inputs and debounce the two buttons.
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      db_cnt_q  <= '0;
    end else begin
      sync1_q   <= {switch_alarm, switch_setting, button_inc, button_pos};
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign pos_ev = db_q[0] & ~db_prev_q[0];
  assign inc_ev = db_q[1] & ~db_prev_q[1];

  // Mode request: alarm editing wins over time editing.
  always_comb begin
    req = REQ_RUN;
    if (sync2_q[3])      req = REQ_ALARM;
    else if (sync2_q[2]) req = REQ_TIME;
  end

  // FSM next state, edit digits, alarm commit and strobes.
  // Commit states take the same entry decision as RUN so a pending request is honoured one cycle later.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    edit_d      = edit_q;
    alarm_d     = alarm_q;
    valid_d     = valid_q;
    enter_edit  = 1'b0;
    load_time   = 1'b0;
    display_sel = 1'b0;
    case (state_q)
      ST_EDIT_TIME, ST_EDIT_ALARM: begin
        display_sel = 1'b1;
        if ((state_q == ST_EDIT_TIME  && req != REQ_TIME) ||
            (state_q == ST_EDIT_ALARM && req != REQ_ALARM)) begin
          state_d = (state_q == ST_EDIT_TIME) ? ST_COMMIT_TIME : ST_COMMIT_ALARM;
        end else begin
          if (inc_ev) edit_d = inc_digit(edit_q, pos_q);
          if (pos_ev) pos_d = pos_q + 2'd1;
        end
      end
      default: begin
        if (state_q == ST_COMMIT_TIME) load_time = 1'b1;
        if (state_q == ST_COMMIT_ALARM) begin
          alarm_d = {edit_q[23:8], 8'h00};
          valid_d = 1'b1;
        end
        state_d = ST_RUN;
        if (req == REQ_ALARM) begin
          state_d    = ST_EDIT_ALARM;
          edit_d     = alarm_d;
          pos_d      = 2'd0;
          enter_edit = 1'b1;
        end else if (req == REQ_TIME) begin
          state_d    = ST_EDIT_TIME;
          edit_d     = {cur_time[23:8], 8'h00};
          pos_d      = 2'd0;
          enter_edit = 1'b1;
        end
      end
    endcase
  end

  // FSM and edit/alarm registers.
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      state_q <= ST_RUN;
      pos_q   <= 2'd0;
      edit_q  <= '0;
      alarm_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      edit_q  <= edit_d;
      alarm_q <= alarm_d;
      valid_q <= valid_d;
    end
  end

  // Ring fires only on the first cycle the running time matches the committed alarm.
  assign ring_match = (state_q == ST_RUN) && valid_q && (cur_time == alarm_q) &&
                      (cur_time != cur_prev_q);

  // Ring window: an inc press or entering an edit cancels it, otherwise it counts down to zero.
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      cur_prev_q <= '0;
      ring_q     <= 1'b0;
      ring_cnt_q <= '0;
    end else begin
      cur_prev_q <= cur_time;
      if (inc_ev || enter_edit) begin
        ring_q     <= 1'b0;
        ring_cnt_q <= '0;
      end else if (ring_match) begin
        ring_q     <= 1'b1;
        ring_cnt_q <= RING_W'(RING_CYCLES);
      end else if (ring_q) begin
        ring_cnt_q <= ring_cnt_q - 1'b1;
        if (ring_cnt_q == RING_W'(1)) ring_q <= 1'b0;
      end
    end
  end

  // Free-running blink phase generator.
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == BL_W'(BLINK_HALF - 1)) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  // Position 0..3 maps to digits ml..hh, i.e. blank bits 2..5.
  always_comb begin
    blank = 6'b0;
    if (display_sel && phase_q) blank = 6'b000100 << pos_q;
  end

  assign edit_time   = edit_q;
  assign alarm_time  = alarm_q;
  assign alarm_valid = valid_q;
  assign ring        = ring_q;

endmodule

// File: tb/tb_clock_edit_controller.sv
// Bench for clock_edit_controller: transaction-level model of the edit digits, alarm and strobes, checked every settled cycle.
// Latency: model updates after each button/switch transaction completes; per-cycle checks pause while one is in flight.
// Backpressure: not applicable; the bench drives the raw switches and buttons directly.

module tb_clock_edit_controller;

  logic        clk_1khz;
  logic        switch_clr;
  logic        button_pos;
  logic        button_inc;
  logic        switch_setting;
  logic        switch_alarm;
  logic [23:0] cur_time;
  logic [23:0] edit_time;
  logic        display_sel;
  logic        load_time;
  logic [23:0] alarm_time;
  logic        alarm_valid;
  logic [5:0]  blank;
  logic        ring;

  int          n_chk;
  int          n_err;

  // model state: mode 0 = run, 1 = time edit, 2 = alarm edit
  logic [23:0] m_edit;
  logic [23:0] m_alarm;
  logic        m_valid;
  logic        m_disp;
  int          m_mode;
  int          m_pos;
  bit          chk_en;
  int          load_cnt;
  logic [23:0] load_val;

  clock_edit_controller dut (
    .clk_1khz       (clk_1khz),
    .switch_clr     (switch_clr),
    .button_pos     (button_pos),
    .button_inc     (button_inc),
    .switch_setting (switch_setting),
    .switch_alarm   (switch_alarm),
    .cur_time       (cur_time),
    .edit_time      (edit_time),
    .display_sel    (display_sel),
    .load_time      (load_time),
    .alarm_time     (alarm_time),
    .alarm_valid    (alarm_valid),
    .blank          (blank),
    .ring           (ring)
  );

  initial begin
    clk_1khz = 1'b0;
    forever #5 clk_1khz = ~clk_1khz;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: end of test not reached, errors so far %0d", n_err);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Clock-digit arithmetic: each edited digit wraps at its own ceiling, hh=2 limits hl to 3.
  function automatic logic [23:0] model_inc(input logic [23:0] t, input int p);
    int          d[6];
    int          lim;
    logic [23:0] r;
    for (int k = 0; k < 6; k++) d[k] = int'(t[4*k +: 4]);
    case (p)
      0:       lim = 9;
      1:       lim = 5;
      2:       lim = (d[5] == 2) ? 3 : 9;
      default: lim = 2;
    endcase
    d[p+2] = (d[p+2] >= lim) ? 0 : d[p+2] + 1;
    if (p == 3 && d[5] == 2 && d[4] > 3) d[4] = 0;
    r = '0;
    for (int k = 0; k < 6; k++) r[4*k +: 4] = 4'(d[k]);
    return r;
  endfunction

  // Load-strobe monitor plus the per-cycle comparison against the model.
  always @(negedge clk_1khz) begin
    if (load_time === 1'b1) begin
      load_cnt++;
      load_val = edit_time;
    end
    if (chk_en) begin
      chk("edit_time", edit_time, m_edit);
      chk("display_sel", display_sel, m_disp);
      chk("alarm_time", alarm_time, m_alarm);
      chk("alarm_valid", alarm_valid, m_valid);
      chk("load_idle", load_time, 1'b0);
      if (!m_disp) chk("blank_idle", blank, 6'b0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_1khz);
    #2;
  endtask

  task automatic press(input bit is_inc);
    chk_en = 1'b0;
    if (is_inc) button_inc = 1'b1;
    else        button_pos = 1'b1;
    step(30);
    button_inc = 1'b0;
    button_pos = 1'b0;
    step(30);
    if (m_mode != 0) begin
      if (is_inc) m_edit = model_inc(m_edit, m_pos);
      else        m_pos  = (m_pos + 1) % 4;
    end
    chk_en = 1'b1;
  endtask

  task automatic presses(input bit is_inc, input int n);
    for (int k = 0; k < n; k++) press(is_inc);
  endtask

  task automatic set_switches(input logic s, input logic a);
    int          nm;
    int          exp_loads;
    logic [23:0] exp_val;
    nm        = a ? 2 : (s ? 1 : 0);
    exp_loads = 0;
    exp_val   = '0;
    chk_en    = 1'b0;
    load_cnt  = 0;
    if (nm != m_mode) begin
      if (m_mode == 1) begin
        exp_loads = 1;
        exp_val   = m_edit;
      end
      if (m_mode == 2) begin
        m_alarm = {m_edit[23:8], 8'h00};
        m_valid = 1'b1;
      end
      if (nm == 1) begin
        m_edit = {cur_time[23:8], 8'h00};
        m_pos  = 0;
      end
      if (nm == 2) begin
        m_edit = m_alarm;
        m_pos  = 0;
      end
      m_mode = nm;
      m_disp = (nm != 0);
    end
    switch_setting = s;
    switch_alarm   = a;
    step(8);
    chk("load_count", load_cnt, exp_loads);
    if (exp_loads == 1) chk("load_value", load_val, exp_val);
    chk_en = 1'b1;
  endtask

  task automatic drive_inc(input logic v, input int n);
    button_inc = v;
    step(n);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_edit_time"}, edit_time, 24'h0);
    chk({tag, "_alarm_time"}, alarm_time, 24'h0);
    chk({tag, "_display_sel"}, display_sel, 1'b0);
    chk({tag, "_load_time"}, load_time, 1'b0);
    chk({tag, "_alarm_valid"}, alarm_valid, 1'b0);
    chk({tag, "_blank"}, blank, 6'b0);
    chk({tag, "_ring"}, ring, 1'b0);
  endtask

  initial begin
    int          hi;
    int          run;
    int          nch;
    int          bad;
    int          seen;
    logic [5:0]  prev;

    n_chk = 0;
    n_err = 0;
    chk_en = 1'b0;
    load_cnt = 0;
    load_val = '0;
    m_edit = '0;
    m_alarm = '0;
    m_valid = 1'b0;
    m_disp = 1'b0;
    m_mode = 0;
    m_pos = 0;
    switch_clr = 1'b0;
    button_pos = 1'b0;
    button_inc = 1'b0;
    switch_setting = 1'b0;
    switch_alarm = 1'b0;
    cur_time = 24'h123456;

    // Reset state
    step(3);
    chk_reset_outputs("reset");
    switch_clr = 1'b1;
    step(3);
    chk_en = 1'b1;

    // 1: time edit from 12:34:56, three increments, commit
    chk_en = 1'b0;
    switch_setting = 1'b1;
    repeat (3) @(posedge clk_1khz);
    #1;
    chk("t1_display_within_3", display_sel, 1'b1);
    chk("t1_edit_secs_cleared", edit_time, 24'h123400);
    set_switches(1'b1, 1'b0);
    presses(1'b1, 3);
    chk("t1_edit_1237", edit_time, 24'h123700);
    set_switches(1'b0, 1'b0);
    chk("t1_load_value_literal", load_val, 24'h123700);

    // 2: hour rules
    cur_time = 24'h190500;
    set_switches(1'b1, 1'b0);
    presses(1'b0, 3);
    press(1'b1);
    chk("t2_hh_clamps_hl", edit_time, 24'h200500);
    presses(1'b0, 3);
    press(1'b1);
    chk("t2_hl_inc", edit_time, 24'h210500);
    set_switches(1'b0, 1'b0);
    cur_time = 24'h230000;
    set_switches(1'b1, 1'b0);
    presses(1'b0, 2);
    press(1'b1);
    chk("t2_hl_wrap_at_3", edit_time, 24'h200000);
    press(1'b0);
    press(1'b1);
    chk("t2_hh_wrap", edit_time, 24'h000000);
    set_switches(1'b0, 1'b0);

    // 3: debounce
    cur_time = 24'h123456;
    set_switches(1'b1, 1'b0);
    chk_en = 1'b0;
    drive_inc(1'b1, 5);
    drive_inc(1'b0, 40);
    chk("t3_glitch_ignored", edit_time, 24'h123400);
    drive_inc(1'b1, 30);
    drive_inc(1'b0, 3);
    drive_inc(1'b1, 2);
    drive_inc(1'b0, 4);
    drive_inc(1'b1, 3);
    drive_inc(1'b0, 40);
    m_edit = model_inc(m_edit, m_pos);
    chk("t3_one_increment", edit_time, 24'h123500);
    chk_en = 1'b1;
    press(1'b1);
    chk("t3_second_press", edit_time, 24'h123600);
    set_switches(1'b0, 1'b0);

    // 4: alarm commit and ring
    cur_time = 24'h120000;
    set_switches(1'b0, 1'b1);
    press(1'b0);
    presses(1'b1, 3);
    press(1'b0);
    presses(1'b1, 7);
    set_switches(1'b0, 1'b0);
    chk("t4_alarm_time", alarm_time, 24'h073000);
    chk("t4_alarm_valid", alarm_valid, 1'b1);
    cur_time = 24'h073000;
    hi = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk_1khz);
      if (ring) hi++;
      else if (hi > 0) break;
    end
    chk("t4_ring_length", hi, 5000);
    step(1);
    chk("t4_ring_done", ring, 1'b0);
    cur_time = 24'h072959;
    step(5);
    cur_time = 24'h073000;
    step(100);
    chk("t4_ring_at_100", ring, 1'b1);
    chk_en = 1'b0;
    button_inc = 1'b1;
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_1khz);
      if (ring) hi++;
      else break;
    end
    chk("t4_ring_cancel_window", (hi >= 20 && hi <= 26), 1'b1);
    step(10);
    button_inc = 1'b0;
    step(30);
    chk("t4_ring_cancelled", ring, 1'b0);
    chk_en = 1'b1;

    // 5: blink at position 1, then alarm request over time edit
    cur_time = 24'h120000;
    set_switches(1'b1, 1'b0);
    press(1'b0);
    @(negedge clk_1khz);
    prev = blank;
    run = 1;
    nch = 0;
    bad = 0;
    for (int i = 0; i < 1300; i++) begin
      @(negedge clk_1khz);
      if (blank !== 6'b0 && blank !== 6'b001000) bad++;
      if (blank !== prev) begin
        if (nch > 0) chk("t5_blink_run", run, 250);
        nch++;
        run = 1;
        prev = blank;
      end else begin
        run++;
      end
    end
    chk("t5_blink_bad_values", bad, 0);
    chk("t5_blink_toggles", (nch >= 4), 1'b1);
    step(1);
    set_switches(1'b1, 1'b1);
    chk("t5_alarm_edit_loaded", edit_time, 24'h073000);
    bad = 0;
    seen = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_1khz);
      if (blank === 6'b000100) seen = 1;
      else if (blank !== 6'b0) bad++;
    end
    chk("t5_pos0_bad_blank", bad, 0);
    chk("t5_pos0_blinks", seen, 1);
    step(1);
    set_switches(1'b0, 1'b0);

    // 6: reset mid-edit
    cur_time = 24'h154200;
    set_switches(1'b1, 1'b0);
    chk_en = 1'b0;
    switch_clr = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    step(3);
    switch_setting = 1'b0;
    switch_clr = 1'b1;
    m_edit = '0;
    m_alarm = '0;
    m_valid = 1'b0;
    m_disp = 1'b0;
    m_mode = 0;
    m_pos = 0;
    load_cnt = 0;
    chk_en = 1'b1;
    step(50);
    chk("t6_no_load_after_reset", load_cnt, 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
